bcd_to_7segment: RTL and testbench



---
 rtl/bcd_to_7segment.sv | 83 ++++++++
 tb/tb_bcd_to_7segment.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bcd_to_7segment.sv
// rtl/bcd_to_7segment.sv - registered single-digit BCD to seven-segment decoder
//
// Ports:
//   clk      in   1  system clock, outputs update on rising edge
//   rst_n    in   1  asynchronous active-low reset (outputs blank, invalid=0)
//   BCD      in   4  digit code, bit 3 is MSB
//   a..g     out  1  segment drives (a=top, b=upper-right, c=lower-right,
//                    d=bottom, e=lower-left, f=upper-left, g=middle)
//   invalid  out  1  registered code was 10..15 (never inverted)
//
// Parameter:
//   SEG_ACTIVE_LOW  0: segment lit when output is 1; 1: all seven segment
//                   outputs inverted (common-anode).

module bcd_to_7segment #(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] BCD,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       invalid
);

    // Logical pattern ordered {a,b,c,d,e,f,g}, 1 = lit.
    logic [6:0] w_seg_next;
    logic       w_invalid_next;
    logic [6:0] r_seg;
    logic       r_invalid;
    logic [6:0] w_seg_phys;

    always_comb begin
        w_seg_next     = 7'b0000000;
        w_invalid_next = 1'b0;
        case (BCD)
            4'd0:    w_seg_next = 7'b1111110;
            4'd1:    w_seg_next = 7'b0110000;
            4'd2:    w_seg_next = 7'b1101101;
            4'd3:    w_seg_next = 7'b1111001;
            4'd4:    w_seg_next = 7'b0110011;
            4'd5:    w_seg_next = 7'b1011011;
            4'd6:    w_seg_next = 7'b1011111;
            4'd7:    w_seg_next = 7'b1110000;
            4'd8:    w_seg_next = 7'b1111111;
            4'd9:    w_seg_next = 7'b1111011;
            default: begin
                w_seg_next     = 7'b0000000;
                w_invalid_next = 1'b1;
            end
        endcase
    end

    // The logical pattern is stored, so reset only has to clear to blank;
    // polarity is applied after the register and depends only on a constant,
    // so there is still no combinational path from BCD to any output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg     <= 7'b0000000;
            r_invalid <= 1'b0;
        end else begin
            r_seg     <= w_seg_next;
            r_invalid <= w_invalid_next;
        end
    end

    assign w_seg_phys = r_seg ^ {7{SEG_ACTIVE_LOW}};

    assign a       = w_seg_phys[6];
    assign b       = w_seg_phys[5];
    assign c       = w_seg_phys[4];
    assign d       = w_seg_phys[3];
    assign e       = w_seg_phys[2];
    assign f       = w_seg_phys[1];
    assign g       = w_seg_phys[0];
    assign invalid = r_invalid;

endmodule

// File: tb/tb_bcd_to_7segment.sv
// tb/tb_bcd_to_7segment.sv - scoreboard bench for bcd_to_7segment, both polarities

module tb_bcd_to_7segment;

    logic       clk;
    logic       rst_n;
    logic [3:0] BCD;

    logic a0, b0, c0, d0, e0, f0, g0, inv0;
    logic a1, b1, c1, d1, e1, f1, g1, inv1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [6:0] seg_hi_true;
        logic [6:0] seg_lo_true;
        logic       inv;
        logic [3:0] code;
    } exp_t;

    exp_t sb_q[$];

    bcd_to_7segment #(.SEG_ACTIVE_LOW(1'b0)) u_dut_pos (
        .clk(clk), .rst_n(rst_n), .BCD(BCD),
        .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0),
        .invalid(inv0)
    );

    bcd_to_7segment #(.SEG_ACTIVE_LOW(1'b1)) u_dut_neg (
        .clk(clk), .rst_n(rst_n), .BCD(BCD),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
        .invalid(inv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each segment is described by the set of digits that light it.
    function automatic logic [6:0] model_seg(input int v);
        logic sa, sb, sc, sd, se, sf, sg;
        if (v > 9) return 7'b0000000;
        sa = !(v inside {1, 4});
        sb = !(v inside {5, 6});
        sc = (v != 2);
        sd = !(v inside {1, 4, 7});
        se = (v inside {0, 2, 6, 8});
        sf = !(v inside {1, 2, 3, 7});
        sg = !(v inside {0, 1, 7});
        return {sa, sb, sc, sd, se, sf, sg};
    endfunction

    function automatic exp_t make_exp(input int v);
        exp_t x;
        x.seg_hi_true = model_seg(v);
        x.seg_lo_true = ~model_seg(v);
        x.inv         = (v > 9);
        x.code        = 4'(v);
        return x;
    endfunction

    function automatic void check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    function automatic void check_all(input string tag, input logic [6:0] e_pos,
                                      input logic [6:0] e_neg, input logic e_inv);
        check({tag, " seg(active-high)"}, {a0, b0, c0, d0, e0, f0, g0}, e_pos);
        check({tag, " seg(active-low)"},  {a1, b1, c1, d1, e1, f1, g1}, e_neg);
        check({tag, " invalid(active-high dut)"}, {6'b0, inv0}, {6'b0, e_inv});
        check({tag, " invalid(active-low dut)"},  {6'b0, inv1}, {6'b0, e_inv});
    endfunction

    // Monitor: the design presents a new decode after every rising edge;
    // each expected entry was queued before the edge that samples it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_t x;
                string tag;
                x = sb_q.pop_front();
                tag = $sformatf("decode code=%0d", x.code);
                check_all(tag, x.seg_hi_true, x.seg_lo_true, x.inv);
            end
        end
    end

    task automatic drive(input int v);
        @(negedge clk);
        BCD = 4'(v);
        sb_q.push_back(make_exp(v));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (sb_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain timeout: %0d entries left, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        BCD   = 4'b1000;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset held", 7'b0000000, 7'b1111111, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(make_exp(8));
        drain();

        for (int i = 0; i <= 15; i++) drive(i);
        drive(0);
        drain();

        for (int i = 0; i < 200; i++) drive(int'($urandom_range(0, 15)));
        drain();

        // Mid-cycle change must not reach the outputs before the next edge.
        drive(3);
        drain();
        @(negedge clk);
        BCD = 4'd5;
        sb_q.push_back(make_exp(5));
        #1;
        check_all("hold before edge", 7'b1111001, ~7'b1111001, 1'b0);
        drain();

        // Asynchronous reset between edges.
        drive(8);
        drain();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async reset", 7'b0000000, 7'b1111111, 1'b0);
        BCD = 4'd12;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset overrides invalid", 7'b0000000, 7'b1111111, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(make_exp(12));
        drive(1);
        drive(0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
